doodle_motion_controller: RTL and testbench

Vertical jump physics and horizontal steering for the doodle. It consumes the collision observer's `doodle_collision` and `ground` outputs and produces the `doodle_x`, `doodle_y` and `doodle_fall_direction` the observer checks against platforms. It also emits a scroll request to the platform scroller whenever the doodle rises past the scroll line. All motion advances once per `frame_tick`; landings are taken on any cycle.

---
 rtl/doodle_pkg.sv | 34 +++
 rtl/doodle_motion_controller_if.sv | 48 ++++
 rtl/doodle_x_stepper.sv | 50 +++++
 rtl/doodle_motion_controller.sv | 157 +++++++++++++++
 tb/tb_doodle_motion_controller.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/doodle_pkg.sv
// Shared doodle types and screen/sprite constants, reused by the collision observer and the
// renderer as well as the motion controller.
package doodle_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall,
        StDead
    } motion_state_t;

    localparam int ScreenWidth  = 800;
    localparam int ScreenHeight = 600;
    localparam int DoodleHeight = 60;
    localparam int StartX       = 370;
    localparam int StartY       = 480;
    localparam int JumpSpeed    = 20;
    localparam int Gravity      = 1;
    localparam int MaxFallSpeed = 20;
    localparam int XStep        = 4;
    localparam int ScrollLine   = 200;

    localparam int XW      = 11;
    localparam int YW      = 10;
    localparam int ScrollW = 8;
    localparam int VelW    = 12;

    typedef logic signed [VelW-1:0] sword_t;

    function automatic sword_t min_s(input sword_t a, input sword_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/doodle_motion_controller_if.sv
// Signal bundle between the motion controller and its environment (frame timing, buttons,
// collision observer, platform scroller). The controller takes the slave side.
interface doodle_motion_controller_if import doodle_pkg::*; ();

    logic                    frame_tick;
    logic                    start;
    logic                    btn_left;
    logic                    btn_right;
    logic                    doodle_collision;
    logic [1:0][YW-1:0]      ground;
    logic [XW-1:0]           doodle_x;
    logic [YW-1:0]           doodle_y;
    logic                    doodle_fall_direction;
    logic                    scroll_valid;
    logic [ScrollW-1:0]      scroll_amount;
    logic                    game_over;

    modport master (
        output frame_tick,
        output start,
        output btn_left,
        output btn_right,
        output doodle_collision,
        output ground,
        input  doodle_x,
        input  doodle_y,
        input  doodle_fall_direction,
        input  scroll_valid,
        input  scroll_amount,
        input  game_over
    );

    modport slave (
        input  frame_tick,
        input  start,
        input  btn_left,
        input  btn_right,
        input  doodle_collision,
        input  ground,
        output doodle_x,
        output doodle_y,
        output doodle_fall_direction,
        output scroll_valid,
        output scroll_amount,
        output game_over
    );

endinterface

// File: rtl/doodle_x_stepper.sv
// Horizontal step for one frame plus screen-edge handling: wraps around when DOODLE_X_WRAP_EN
// is defined, otherwise clamps to [0, SCREEN_WIDTH-1].
module doodle_x_stepper import doodle_pkg::*; #(
    parameter int SCREEN_WIDTH = ScreenWidth,
    parameter int X_STEP       = XStep
) (
    input  logic [XW-1:0] x,
    input  logic          left,
    input  logic          right,
    output logic [XW-1:0] x_next
);

    localparam sword_t WidthS = sword_t'(SCREEN_WIDTH);
    localparam sword_t StepS  = sword_t'(X_STEP);

    sword_t x_s;
    sword_t stepped;
    sword_t fixed;

    always_comb begin
        x_s     = sword_t'({1'b0, x});
        stepped = x_s;
        if (left && !right) begin
            stepped = x_s - StepS;
        end else if (right && !left) begin
            stepped = x_s + StepS;
        end

`ifdef DOODLE_X_WRAP_EN
        if (stepped < sword_t'(0)) begin
            fixed = stepped + WidthS;
        end else if (stepped >= WidthS) begin
            fixed = stepped - WidthS;
        end else begin
            fixed = stepped;
        end
`else
        if (stepped < sword_t'(0)) begin
            fixed = '0;
        end else if (stepped > WidthS - sword_t'(1)) begin
            fixed = WidthS - sword_t'(1);
        end else begin
            fixed = stepped;
        end
`endif

        x_next = fixed[XW-1:0];
    end

endmodule

// File: rtl/doodle_motion_controller.sv
// Doodle jump physics (rise/fall/land/die) and steering, advanced once per frame_tick.
// Edge behaviour of x is selected by DOODLE_X_WRAP_EN inside doodle_x_stepper.
module doodle_motion_controller import doodle_pkg::*; #(
    parameter int SCREEN_WIDTH   = ScreenWidth,
    parameter int SCREEN_HEIGHT  = ScreenHeight,
    parameter int DOODLE_HEIGHT  = DoodleHeight,
    parameter int START_X        = StartX,
    parameter int START_Y        = StartY,
    parameter int JUMP_SPEED     = JumpSpeed,
    parameter int GRAVITY        = Gravity,
    parameter int MAX_FALL_SPEED = MaxFallSpeed,
    parameter int X_STEP         = XStep,
    parameter int SCROLL_LINE    = ScrollLine
) (
    input logic                  clk,
    input logic                  rst,
    doodle_motion_controller_if.slave bus
);

    localparam sword_t JumpS    = sword_t'(JUMP_SPEED);
    localparam sword_t GravS    = sword_t'(GRAVITY);
    localparam sword_t MaxFallS = sword_t'(MAX_FALL_SPEED);
    localparam sword_t ScrollS  = sword_t'(SCROLL_LINE);
    localparam sword_t HeightS  = sword_t'(DOODLE_HEIGHT);
    localparam sword_t DeadS    = sword_t'(SCREEN_HEIGHT - DOODLE_HEIGHT);

    motion_state_t      state_q, state_d;
    sword_t             vel_q, vel_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               fall_q, fall_d;
    logic               scroll_valid_q, scroll_valid_d;
    logic [ScrollW-1:0] scroll_amount_q, scroll_amount_d;
    logic               game_over_q, game_over_d;

    logic [XW-1:0] x_stepped;
    sword_t        y_s;
    sword_t        rise_next;
    sword_t        fall_next;
    sword_t        scroll_amt;
    sword_t        land_y;
    sword_t        vel_fall;

    // Only the landed platform matters here; ground[1] belongs to the observer.
    logic unused_ground;
    assign unused_ground = ^bus.ground[1];

    doodle_x_stepper #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .X_STEP       (X_STEP)
    ) u_x_stepper (
        .x      (x_q),
        .left   (bus.btn_left),
        .right  (bus.btn_right),
        .x_next (x_stepped)
    );

    assign y_s        = sword_t'({2'b00, y_q});
    assign rise_next  = y_s - vel_q;
    assign fall_next  = y_s + vel_q;
    assign scroll_amt = ScrollS - rise_next;
    assign land_y     = sword_t'({2'b00, bus.ground[0]}) - HeightS;
    assign vel_fall   = min_s(vel_q + GravS, MaxFallS);

    always_comb begin
        state_d         = state_q;
        vel_d           = vel_q;
        x_d             = x_q;
        y_d             = y_q;
        fall_d          = fall_q;
        scroll_valid_d  = 1'b0;
        scroll_amount_d = scroll_amount_q;
        game_over_d     = game_over_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRise;
                    vel_d   = JumpS;
                    fall_d  = 1'b0;
                end
            end
            StRise: begin
                if (bus.frame_tick) begin
                    x_d = x_stepped;
                    if (vel_q <= GravS) begin
                        state_d = StFall;
                        vel_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        // Above the scroll line the world moves instead of the doodle.
                        if (rise_next < ScrollS) begin
                            y_d             = ScrollS[YW-1:0];
                            scroll_amount_d = scroll_amt[ScrollW-1:0];
                            scroll_valid_d  = 1'b1;
                        end else begin
                            y_d = rise_next[YW-1:0];
                        end
                        vel_d = vel_q - GravS;
                    end
                end
            end
            StFall: begin
                // A landing wins over a coincident tick; that frame's motion is dropped.
                if (bus.doodle_collision) begin
                    y_d     = land_y[YW-1:0];
                    state_d = StRise;
                    vel_d   = JumpS;
                    fall_d  = 1'b0;
                end else if (bus.frame_tick) begin
                    x_d   = x_stepped;
                    y_d   = fall_next[YW-1:0];
                    vel_d = vel_fall;
                    if (fall_next > DeadS) begin
                        state_d     = StDead;
                        game_over_d = 1'b1;
                    end
                end
            end
            StDead: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            vel_q           <= '0;
            x_q             <= XW'(START_X);
            y_q             <= YW'(START_Y);
            fall_q          <= 1'b0;
            scroll_valid_q  <= 1'b0;
            scroll_amount_q <= '0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            vel_q           <= vel_d;
            x_q             <= x_d;
            y_q             <= y_d;
            fall_q          <= fall_d;
            scroll_valid_q  <= scroll_valid_d;
            scroll_amount_q <= scroll_amount_d;
            game_over_q     <= game_over_d;
        end
    end

    assign bus.doodle_x              = x_q;
    assign bus.doodle_y              = y_q;
    assign bus.doodle_fall_direction = fall_q;
    assign bus.scroll_valid          = scroll_valid_q;
    assign bus.scroll_amount         = scroll_amount_q;
    assign bus.game_over             = game_over_q;

endmodule

// File: tb/tb_doodle_motion_controller.sv
// Directed and random checks of doodle_motion_controller against a behavioural model of the
// jump rules; honours DOODLE_X_WRAP_EN the same way the design does.
module tb_doodle_motion_controller;

    localparam int MIdle = 0;
    localparam int MRise = 1;
    localparam int MFall = 2;
    localparam int MDead = 3;

    localparam int W      = 800;
    localparam int H      = 600;
    localparam int DH     = 60;
    localparam int SX     = 370;
    localparam int SY     = 480;
    localparam int JUMP   = 20;
    localparam int GRAV   = 1;
    localparam int MAXF   = 20;
    localparam int STEP   = 4;
    localparam int SLINE  = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    doodle_motion_controller_if bus ();

    doodle_motion_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_state, m_vel, m_x, m_y, m_fd, m_sv, m_sa, m_go;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    function automatic void model_reset();
        m_state = MIdle; m_vel = 0; m_x = SX; m_y = SY;
        m_fd = 0; m_sv = 0; m_sa = 0; m_go = 0;
    endfunction

    function automatic int move_x(input int x, input bit l, input bit r);
        int nx;
        nx = x;
        if (l && !r) nx = x - STEP;
        if (r && !l) nx = x + STEP;
`ifdef DOODLE_X_WRAP_EN
        if (nx < 0) nx += W;
        else if (nx >= W) nx -= W;
`else
        if (nx < 0) nx = 0;
        else if (nx > W - 1) nx = W - 1;
`endif
        return nx;
    endfunction

    function automatic void model_step(input bit r, input bit tick, input bit st, input bit l,
                                       input bit rt, input bit coll, input int g);
        int n;
        if (r) begin
            model_reset();
            return;
        end
        m_sv = 0;
        if (m_state == MIdle) begin
            if (st) begin m_state = MRise; m_vel = JUMP; m_fd = 0; end
        end else if (m_state == MRise) begin
            if (tick) begin
                m_x = move_x(m_x, l, rt);
                if (m_vel <= GRAV) begin
                    m_state = MFall; m_vel = 0; m_fd = 1;
                end else begin
                    n = m_y - m_vel;
                    if (n < SLINE) begin
                        m_y = SLINE; m_sa = (SLINE - n) & 255; m_sv = 1;
                    end else begin
                        m_y = n & 1023;
                    end
                    m_vel -= GRAV;
                end
            end
        end else if (m_state == MFall) begin
            if (coll) begin
                m_y = (g - DH) & 1023; m_state = MRise; m_vel = JUMP; m_fd = 0;
            end else if (tick) begin
                m_x = move_x(m_x, l, rt);
                m_y = m_y + m_vel;
                m_vel = (m_vel + GRAV > MAXF) ? MAXF : m_vel + GRAV;
                if (m_y > H - DH) begin m_state = MDead; m_go = 1; end
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".x"}, 32'(bus.doodle_x), m_x);
        chk({tag, ".y"}, 32'(bus.doodle_y), m_y);
        chk({tag, ".fall_dir"}, 32'(bus.doodle_fall_direction), m_fd);
        chk({tag, ".scroll_valid"}, 32'(bus.scroll_valid), m_sv);
        chk({tag, ".scroll_amount"}, 32'(bus.scroll_amount), m_sa);
        chk({tag, ".game_over"}, 32'(bus.game_over), m_go);
    endtask

    task automatic cyc(input bit r, input bit tick, input bit st, input bit l, input bit rt,
                       input bit coll, input int g0, input int g1, input string tag);
        rst                  = r;
        bus.frame_tick       = tick;
        bus.start            = st;
        bus.btn_left         = l;
        bus.btn_right        = rt;
        bus.doodle_collision = coll;
        bus.ground[0]        = g0[9:0];
        bus.ground[1]        = g1[9:0];
        @(posedge clk);
        model_step(r, tick, st, l, rt, coll, g0);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int exp_y[5];
        int guard;
        int prev_y;
        int hold_x;
        int hold_y;
        bit was2;
        exp_y = '{460, 441, 423, 406, 390};
        model_reset();
        rst = 1'b1;
        bus.frame_tick = 0; bus.start = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.doodle_collision = 0; bus.ground = '0;

        // Reset, taken together with a tick.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
        chk("reset_x_abs", 32'(bus.doodle_x), SX);
        chk("reset_y_abs", 32'(bus.doodle_y), SY);

        // Take-off and first five frames.
        cyc(0, 0, 1, 0, 0, 0, 0, 0, "start");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, "rise5");
            chk("rise5_y_abs", 32'(bus.doodle_y), exp_y[i]);
            chk("rise5_dir_abs", 32'(bus.doodle_fall_direction), 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, "gap");
        end

        // Jump runs out: FALL entered with y unchanged.
        guard = 0;
        prev_y = m_y;
        while (m_state != MFall && guard < 40) begin
            prev_y = m_y;
            cyc(0, 1, 0, 0, 0, 0, 0, 0, "rise_out");
            guard++;
        end
        if (m_state != MFall) bound_fail("rise_to_fall");
        else begin
            chk("fall_entry_y", 32'(bus.doodle_y), prev_y);
            chk("fall_entry_y_abs", 32'(bus.doodle_y), 271);
            chk("fall_entry_dir", 32'(bus.doodle_fall_direction), 1);
        end

        // Land at 509 so the next jump tops out at exactly 300.
        cyc(0, 0, 0, 0, 0, 1, 569, 0, "land509");
        guard = 0;
        while (m_state != MFall && guard < 40) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, "rise300");
            guard++;
        end
        if (m_state != MFall) bound_fail("rise300");
        else chk("fall_at_300", 32'(bus.doodle_y), 300);
        cyc(0, 1, 0, 0, 0, 1, 350, 0, "land_tick");
        chk("land_tick_y_abs", 32'(bus.doodle_y), 290);
        chk("land_tick_dir_abs", 32'(bus.doodle_fall_direction), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "after_land");
        chk("after_land_y_abs", 32'(bus.doodle_y), 270);

        // Scroll: y=210, vel=18 on a tick.
        guard = 0;
        while (m_state != MFall && guard < 40) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, "to_fall");
            guard++;
        end
        if (m_state != MFall) bound_fail("to_fall");
        cyc(0, 0, 0, 0, 0, 1, 309, 0, "land249");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "s1");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "s2");
        chk("pre_scroll_y_abs", 32'(bus.doodle_y), 210);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, "scroll");
        chk("scroll_y_abs", 32'(bus.doodle_y), 200);
        chk("scroll_valid_abs", 32'(bus.scroll_valid), 1);
        chk("scroll_amount_abs", 32'(bus.scroll_amount), 8);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "scroll_after");
        chk("scroll_valid_drop", 32'(bus.scroll_valid), 0);
        chk("scroll_amount_hold", 32'(bus.scroll_amount), 8);

        // Steer left past the left edge, landing whenever the doodle falls.
        guard = 0;
        was2 = 0;
        while (guard < 400) begin
            if (m_state == MFall) begin
                cyc(0, 0, 0, 0, 0, 1, 540, 0, "steer_land");
            end else begin
                was2 = (m_x == 2);
                cyc(0, 1, 0, 1, 0, 0, 0, 0, "steer_left");
                if (was2) break;
            end
            guard++;
        end
        if (!was2) bound_fail("steer_to_edge");
        else begin
`ifdef DOODLE_X_WRAP_EN
            chk("edge_x_abs", 32'(bus.doodle_x), 798);
`else
            chk("edge_x_abs", 32'(bus.doodle_x), 0);
`endif
        end
        if (m_state == MFall) cyc(0, 0, 0, 0, 0, 1, 540, 0, "steer_land");
        hold_x = m_x;
        cyc(0, 1, 0, 1, 1, 0, 0, 0, "both_btn");
        chk("both_btn_x", 32'(bus.doodle_x), hold_x);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, "right");

        // Fall to death, then everything but rst is ignored.
        guard = 0;
        while (m_state != MDead && guard < 100) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, "to_dead");
            guard++;
        end
        if (m_state != MDead) bound_fail("to_dead");
        chk("dead_game_over_abs", 32'(bus.game_over), 1);
        hold_x = m_x;
        hold_y = m_y;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 0, 1, 300, 0, "dead_hold");
            chk("dead_x_hold", 32'(bus.doodle_x), hold_x);
            chk("dead_y_hold", 32'(bus.doodle_y), hold_y);
        end
        cyc(1, 1, 0, 0, 0, 1, 300, 0, "dead_reset");
        chk("rst_game_over_abs", 32'(bus.game_over), 0);
        chk("rst_y_abs", 32'(bus.doodle_y), SY);
        chk("rst_x_abs", 32'(bus.doodle_x), SX);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 400) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                1'($urandom), 1'($urandom), ($urandom % 6) == 0,
                int'($urandom_range(560, 100)), int'($urandom % 1024), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
